// File: rtl/event_unit_pkg.sv
// rtl/event_unit_pkg.sv - shared types and constants for the event unit IRQ scheduler
package event_unit_pkg;

   localparam int IRQ_ID_W = 5;
   localparam int MAX_IRQ  = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_sched_state_e;

endpackage

// File: rtl/event_unit_prio_enc.sv
// rtl/event_unit_prio_enc.sv - wrapping find-first-set; start_i=0 gives fixed lowest-index priority
module event_unit_prio_enc
   import event_unit_pkg::*;
#(
   parameter int NUM_IRQ = 32
) (
   input  logic [NUM_IRQ-1:0]  req_i,
   input  logic [IRQ_ID_W-1:0] start_i,
   output logic                valid_o,
   output logic [IRQ_ID_W-1:0] id_o
);

   localparam int SW = IRQ_ID_W + 1;

   logic [NUM_IRQ-1:0] rot;
   logic [SW-1:0]      sum;

   // Rotate so the start index lands on bit 0; the lowest set bit of rot is the winner.
   assign rot = NUM_IRQ'({req_i, req_i} >> start_i);

   always_comb begin
      valid_o = 1'b0;
      sum     = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid_o = 1'b1;
            sum     = SW'(start_i) + SW'(i);
         end
      end
      if (sum >= SW'(NUM_IRQ)) begin
         sum = sum - SW'(NUM_IRQ);
      end
      id_o = sum[IRQ_ID_W-1:0];
   end

endmodule

// File: rtl/event_unit_irq_sched.sv
// rtl/event_unit_irq_sched.sv - IRQ scheduler: req/ack/eoi handshake with the core, ack timeout.
// EVENT_UNIT_IRQ_RR_EN selects round-robin arbitration; fixed priority otherwise.
module event_unit_irq_sched
   import event_unit_pkg::*;
#(
   parameter int NUM_IRQ     = 32,
   parameter int ACK_TIMEOUT = 256
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic [NUM_IRQ-1:0]  irq_pending_i,
   input  logic [NUM_IRQ-1:0]  irq_enable_i,
   input  logic                sched_en_i,
   output logic                irq_req_o,
   output logic [IRQ_ID_W-1:0] irq_id_o,
   input  logic                irq_ack_i,
   input  logic                irq_eoi_i,
   output logic [NUM_IRQ-1:0]  irq_clr_o,
   output logic                timeout_o,
   output logic                busy_o
);

   localparam int             CNT_W   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam bit             TO_EN   = (ACK_TIMEOUT != 0);
   localparam [CNT_W-1:0]     CNT_SAT = CNT_W'(ACK_TIMEOUT);
   localparam [CNT_W-1:0]     TO_LAST = TO_EN ? CNT_W'(ACK_TIMEOUT - 1) : '0;

   irq_sched_state_e    state_q;
   logic                req_q;
   logic                busy_q;
   logic                timeout_q;
   logic [IRQ_ID_W-1:0] id_q;
   logic [IRQ_ID_W-1:0] last_grant_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [NUM_IRQ-1:0]  clr_q;

   logic [NUM_IRQ-1:0]  cand;
   logic [MAX_IRQ-1:0]  cand_ext;
   logic [MAX_IRQ-1:0]  onehot_ext;
   logic [IRQ_ID_W-1:0] arb_start;
   logic                arb_valid;
   logic [IRQ_ID_W-1:0] arb_id;

   assign cand       = irq_pending_i & irq_enable_i;
   assign cand_ext   = MAX_IRQ'(cand);
   assign onehot_ext = MAX_IRQ'(1) << id_q;

`ifdef EVENT_UNIT_IRQ_RR_EN
   assign arb_start = (last_grant_q == IRQ_ID_W'(NUM_IRQ - 1)) ? '0 : last_grant_q + IRQ_ID_W'(1);
`else
   assign arb_start = '0;
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant_q;
`endif

   event_unit_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio_enc (
      .req_i   (cand),
      .start_i (arb_start),
      .valid_o (arb_valid),
      .id_o    (arb_id)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         id_q         <= '0;
         last_grant_q <= IRQ_ID_W'(NUM_IRQ - 1);
         cnt_q        <= '0;
         clr_q        <= '0;
      end else begin
         clr_q     <= '0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sched_en_i && arb_valid) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  id_q    <= arb_id;
                  cnt_q   <= '0;
               end
            end
            REQ: begin
               if (cnt_q != CNT_SAT) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               // Ack beats withdraw and timeout in the same cycle.
               if (irq_ack_i) begin
                  state_q      <= SERVICE;
                  req_q        <= 1'b0;
                  clr_q        <= onehot_ext[NUM_IRQ-1:0];
                  last_grant_q <= id_q;
               end else if (!cand_ext[id_q] || !sched_en_i) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (TO_EN && (cnt_q == TO_LAST)) begin
                  state_q      <= IDLE;
                  req_q        <= 1'b0;
                  busy_q       <= 1'b0;
                  timeout_q    <= 1'b1;
                  last_grant_q <= id_q;
               end
            end
            SERVICE: begin
               if (irq_eoi_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign irq_req_o = req_q;
   assign irq_id_o  = id_q;
   assign irq_clr_o = clr_q;
   assign timeout_o = timeout_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_event_unit_irq_sched.sv
// tb/tb_event_unit_irq_sched.sv - directed and randomized check of event_unit_irq_sched against a behavioural model
module tb_event_unit_irq_sched;

   localparam int NUM = 32;
   localparam int TO  = 4;
`ifdef EVENT_UNIT_IRQ_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic            HCLK = 1'b0;
   logic            HRESETn = 1'b0;
   logic [NUM-1:0]  pend = '0;
   logic [NUM-1:0]  en = '0;
   logic            sen = 1'b0;
   logic            ack = 1'b0;
   logic            eoi = 1'b0;
   logic            req;
   logic [4:0]      id;
   logic [NUM-1:0]  clr;
   logic            to;
   logic            busy;

   int n_chk = 0;
   int n_fail = 0;

   event_unit_irq_sched #(
      .NUM_IRQ     (NUM),
      .ACK_TIMEOUT (TO)
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .irq_pending_i (pend),
      .irq_enable_i  (en),
      .sched_en_i    (sen),
      .irq_req_o     (req),
      .irq_id_o      (id),
      .irq_ack_i     (ack),
      .irq_eoi_i     (eoi),
      .irq_clr_o     (clr),
      .timeout_o     (to),
      .busy_o        (busy)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   // Winner = first candidate found scanning upward from the search start, wrapping.
   function automatic int pick(input logic [31:0] c, input int last);
      int s;
      s = RR ? (last + 1) % NUM : 0;
      for (int k = 0; k < NUM; k++) begin
         if (c[(s + k) % NUM]) return (s + k) % NUM;
      end
      return 0;
   endfunction

   // Model: 0 idle, 1 requesting, 2 in service; m_age = cycles the request has been visible.
   int          m_mode = 0;
   logic [4:0]  m_id = '0;
   int          m_age = 0;
   int          m_last = NUM - 1;
   logic [31:0] m_clr = '0;
   logic        m_to = 1'b0;

   always @(posedge HCLK or negedge HRESETn) begin : model
      logic [31:0] c;
      if (!HRESETn) begin
         m_mode = 0; m_id = '0; m_age = 0; m_last = NUM - 1; m_clr = '0; m_to = 1'b0;
      end else begin
         c = pend & en;
         m_clr = '0;
         m_to = 1'b0;
         case (m_mode)
            0: if (sen && c != 0) begin
                  m_mode = 1; m_id = 5'(pick(c, m_last)); m_age = 1;
               end
            1: if (ack) begin
                  m_clr = 32'd1 << m_id; m_last = int'(m_id); m_mode = 2;
               end else if (!c[m_id] || !sen) begin
                  m_mode = 0;
               end else if (m_age == TO) begin
                  m_to = 1'b1; m_last = int'(m_id); m_mode = 0;
               end else begin
                  m_age++;
               end
            default: if (eoi) m_mode = 0;
         endcase
      end
   end

   always @(negedge HCLK) begin
      check("req", 32'(req), 32'(m_mode == 1));
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("id", 32'(id), 32'(m_id));
      check("clr", clr, m_clr);
      check("timeout", 32'(to), 32'(m_to));
   end

   initial begin
      int exp_ids[4];
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_req", 32'(req), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_clr", clr, 0);
      HRESETn = 1'b1;
      en = '1;
      sen = 1'b1;

      // fixed priority pick, single-cycle clear, back-to-back after eoi
      pend = 32'h14;
      tick();
      check("t1_req", 32'(req), 1);
      check("t1_id", 32'(id), 2);
      ack = 1'b1; tick(); ack = 1'b0; pend = 32'h10;
      check("t1_clr", clr, 32'h4);
      tick();
      check("t1_clr_off", clr, 0);
      eoi = 1'b1; tick(); eoi = 1'b0;
      check("t1_gap", 32'(req), 0);
      tick();
      check("t1_next_id", 32'(id), 4);
      check("t1_next_req", 32'(req), 1);
      ack = 1'b1; tick(); ack = 1'b0; pend = '0;
      eoi = 1'b1; tick(); eoi = 1'b0;
      tick();

      // withdraw, then same-cycle ack and clear
      pend = 32'h80; tick();
      check("t2_id", 32'(id), 7);
      pend = '0; tick();
      check("t2_wd_req", 32'(req), 0);
      check("t2_wd_clr", clr, 0);
      check("t2_wd_busy", 32'(busy), 0);
      pend = 32'h80; tick();
      ack = 1'b1; pend = '0; tick(); ack = 1'b0;
      check("t2_ack_wins", clr, 32'h80);
      eoi = 1'b1; tick(); eoi = 1'b0; tick();

      // ack timeout on line 3
      pend = 32'h8;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t3_req_high", 32'(req), 1);
         check("t3_no_to", 32'(to), 0);
      end
      tick();
      check("t3_req_low", 32'(req), 0);
      check("t3_to", 32'(to), 1);
      pend = 32'h208;
      tick();
      check("t3_to_pulse", 32'(to), 0);
      check("t3_next_id", 32'(id), RR ? 32'd9 : 32'd3);
      pend = '0; tick(); tick();

      // two held lines: rotation vs fixed priority
      exp_ids = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
      pend = 32'h3;
      for (int g = 0; g < 4; g++) begin
         tick();
         check("t4_rr_id", 32'(id), 32'(exp_ids[g]));
         ack = 1'b1; tick(); ack = 1'b0;
         eoi = 1'b1; tick(); eoi = 1'b0;
      end
      pend = '0; tick();

      // gating and stray handshakes
      sen = 1'b0; pend = '1; tick(); tick();
      check("t5_gated", 32'(req), 0);
      ack = 1'b1; tick(); ack = 1'b0;
      check("t5_stray_ack", 32'(busy), 0);
      sen = 1'b1; tick();
      ack = 1'b1; tick(); ack = 1'b0; sen = 1'b0;
      tick(); tick();
      check("t5_svc_hold", 32'(busy), 1);
      eoi = 1'b1; tick(); eoi = 1'b0;
      check("t5_eoi", 32'(busy), 0);
      sen = 1'b1; tick();
      eoi = 1'b1; tick(); eoi = 1'b0;
      check("t5_stray_eoi", 32'(req), 1);

      // async reset while requesting
      #2 HRESETn = 1'b0;
      #1;
      check("t6_req", 32'(req), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_clr", clr, 0);
      tick(); tick();
      HRESETn = 1'b1;
      pend = 32'h3;
      tick();
      check("t6_first_id", 32'(id), 0);
      ack = 1'b1; tick(); ack = 1'b0;
      eoi = 1'b1; tick(); eoi = 1'b0;
      tick();
      check("t6_second_id", 32'(id), RR ? 32'd1 : 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) pend = (|$urandom_range(0, 1)) ? $urandom : (32'd1 << $urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) en = (|$urandom_range(0, 1)) ? '1 : $urandom;
         sen = ($urandom_range(0, 9) != 0);
         ack = ($urandom_range(0, 3) == 0);
         eoi = ($urandom_range(0, 3) == 0);
         tick();
      end
      ack = 1'b0; eoi = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
